bp_commit_trace_tx: RTL and testbench

BP_COMMIT_TRACE_TX -- requirements
Module: bp_commit_trace_tx

---
 rtl/bp_commit_trace_tx.sv | 187 ++++++++++++++++++
 tb/tb_bp_commit_trace_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_commit_trace_tx.sv
// Commit trace transmitter: queues retired instructions and traps, then serialises
// each as a header beat, an address/cause beat and (for rd writes) a writeback beat.
module bp_commit_trace_tx #(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned hartid_width_p = 4,
  parameter int unsigned els_p          = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [hartid_width_p-1:0] hartid_i,
  input  logic                      commit_v_i,
  input  logic [vaddr_width_p-1:0]  commit_pc_i,
  input  logic [31:0]               commit_instr_i,
  input  logic                      commit_rd_w_v_i,
  input  logic                      interrupt_v_i,
  input  logic [63:0]               cause_i,
  input  logic                      wb_v_i,
  input  logic [63:0]               wb_data_i,
  output logic                      tx_v_o,
  output logic [63:0]               tx_data_o,
  input  logic                      tx_ready_i,
  output logic                      overflow_o,
  output logic [31:0]               pkt_cnt_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam int unsigned ext_w_lp = 64 - vaddr_width_p;

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] hdr_s  = 2'd1;
  localparam logic [1:0] addr_s = 2'd2;
  localparam logic [1:0] data_s = 2'd3;

  typedef struct packed {
    logic                     trap;
    logic [vaddr_width_p-1:0] pc;
    logic [31:0]              instr;
    logic                     rd_w_v;
    logic [63:0]              cause;
  } entry_s;

  entry_s              cq_mem_q [els_p];
  logic [63:0]         wb_mem_q [els_p];
  logic [ptr_w_lp-1:0] cq_rd_q, cq_rd_d, cq_wr_q, cq_wr_d;
  logic [ptr_w_lp-1:0] wb_rd_q, wb_rd_d, wb_wr_q, wb_wr_d;
  logic [cnt_w_lp-1:0] cq_cnt_q, cq_cnt_d, wb_cnt_q, wb_cnt_d, wb_left;
  logic [1:0]          state_q, state_d;
  logic                tx_v_q, tx_v_d, overflow_q, overflow_d;
  logic [63:0]         tx_data_q, tx_data_d, wb_head_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic                cq_full, wb_full, cq_push, wb_push, cq_pop, wb_pop, accept;
  entry_s              cq_entry, cq_head;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign cq_full = (cq_cnt_q == cnt_w_lp'(els_p));
  assign wb_full = (wb_cnt_q == cnt_w_lp'(els_p));
  assign cq_push = (commit_v_i | interrupt_v_i) & ~cq_full;
  assign wb_push = wb_v_i & ~wb_full;
  assign cq_head = cq_mem_q[cq_rd_q];
  assign accept  = tx_v_q & tx_ready_i;

  // A trap wins over a simultaneous commit; commit fields are discarded
  always_comb begin
    cq_entry      = '0;
    cq_entry.trap = interrupt_v_i;
    if (interrupt_v_i) begin
      cq_entry.cause = cause_i;
    end else begin
      cq_entry.pc     = commit_pc_i;
      cq_entry.instr  = commit_instr_i;
      cq_entry.rd_w_v = commit_rd_w_v_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    cq_pop    = 1'b0;
    wb_pop    = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      idle_s: if (cq_cnt_q != '0) state_d = hdr_s;
      hdr_s:  if (accept) state_d = addr_s;
      addr_s: begin
        if (accept) begin
          if (!cq_head.trap && cq_head.rd_w_v) begin
            state_d = data_s;
          end else begin
            cq_pop    = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = idle_s;
          end
        end
      end
      data_s: begin
        if (accept) begin
          cq_pop    = 1'b1;
          wb_pop    = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = idle_s;
        end
      end
      default: state_d = idle_s;
    endcase
  end

  always_comb begin
    cq_rd_d    = cq_pop  ? ptr_inc(cq_rd_q) : cq_rd_q;
    cq_wr_d    = cq_push ? ptr_inc(cq_wr_q) : cq_wr_q;
    wb_rd_d    = wb_pop  ? ptr_inc(wb_rd_q) : wb_rd_q;
    wb_wr_d    = wb_push ? ptr_inc(wb_wr_q) : wb_wr_q;
    cq_cnt_d   = cq_cnt_q + cnt_w_lp'(cq_push) - cnt_w_lp'(cq_pop);
    wb_cnt_d   = wb_cnt_q + cnt_w_lp'(wb_push) - cnt_w_lp'(wb_pop);
    wb_left    = wb_cnt_q - cnt_w_lp'(wb_pop);
    overflow_d = overflow_q | (commit_v_i | interrupt_v_i) & cq_full | wb_v_i & wb_full;
  end

  // Next writeback head: bypass the incoming data when the queue would otherwise be empty
  assign wb_head_d = (wb_left == '0) ? wb_data_i : wb_mem_q[wb_rd_d];

  // Registered beat computed from the next state
  always_comb begin
    tx_v_d    = 1'b0;
    tx_data_d = '0;
    case (state_d)
      hdr_s: begin
        tx_v_d    = 1'b1;
        tx_data_d = cq_head.trap
                  ? {2'b10, 4'(hartid_i), 58'b0}
                  : {2'b01, 4'(hartid_i), cq_head.rd_w_v, 25'b0, cq_head.instr};
      end
      addr_s: begin
        tx_v_d    = 1'b1;
        tx_data_d = cq_head.trap ? cq_head.cause
                  : {{ext_w_lp{cq_head.pc[vaddr_width_p-1]}}, cq_head.pc};
      end
      data_s: begin
        tx_v_d    = (wb_cnt_d != '0);
        tx_data_d = (wb_cnt_d != '0) ? wb_head_d : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= idle_s;
      cq_rd_q    <= '0;
      cq_wr_q    <= '0;
      wb_rd_q    <= '0;
      wb_wr_q    <= '0;
      cq_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      tx_v_q     <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cq_rd_q    <= cq_rd_d;
      cq_wr_q    <= cq_wr_d;
      wb_rd_q    <= wb_rd_d;
      wb_wr_q    <= wb_wr_d;
      cq_cnt_q   <= cq_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      tx_v_q     <= tx_v_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge clk_i) begin
    if (cq_push) cq_mem_q[cq_wr_q] <= cq_entry;
    if (wb_push) wb_mem_q[wb_wr_q] <= wb_data_i;
  end

  assign tx_v_o     = tx_v_q;
  assign tx_data_o  = tx_data_q;
  assign overflow_o = overflow_q;
  assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_bp_commit_trace_tx.sv
// Self-checking bench for bp_commit_trace_tx: directed scenarios plus randomized bursts,
// with every accepted beat compared against a queue-based packet model.
`timescale 1ns/1ps
module tb_bp_commit_trace_tx;
  localparam int unsigned VA = 39;
  localparam int unsigned ELS = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [3:0]  hartid_i = '0;
  logic        commit_v_i = 1'b0;
  logic [VA-1:0] commit_pc_i = '0;
  logic [31:0] commit_instr_i = '0;
  logic        commit_rd_w_v_i = 1'b0;
  logic        interrupt_v_i = 1'b0;
  logic [63:0] cause_i = '0;
  logic        wb_v_i = 1'b0;
  logic [63:0] wb_data_i = '0;
  logic        tx_v_o;
  logic [63:0] tx_data_o;
  logic        tx_ready_i = 1'b1;
  logic        overflow_o;
  logic [31:0] pkt_cnt_o;

  always #5 clk_i = ~clk_i;

  bp_commit_trace_tx #(.vaddr_width_p(VA), .hartid_width_p(4), .els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hartid_i(hartid_i),
    .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
    .commit_rd_w_v_i(commit_rd_w_v_i), .interrupt_v_i(interrupt_v_i), .cause_i(cause_i),
    .wb_v_i(wb_v_i), .wb_data_i(wb_data_i), .tx_v_o(tx_v_o), .tx_data_o(tx_data_o),
    .tx_ready_i(tx_ready_i), .overflow_o(overflow_o), .pkt_cnt_o(pkt_cnt_o)
  );

  typedef struct {
    bit          trap;
    logic [63:0] pc;
    logic [31:0] instr;
    bit          rd;
    logic [63:0] cause;
  } ev_t;

  ev_t         mcq[$];
  logic [63:0] mwb[$];
  logic [63:0] log_q[$];
  int          bi = 0;
  int unsigned mpkts = 0;
  bit          movf = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data = '0;
  int          errors = 0;
  int          checks = 0;
  int          wb_pending = 0;
  int          m_cq_sz0, m_wb_sz0;
  logic [63:0] m_exp;
  bit          m_fin;
  ev_t         m_ev;

  function automatic logic [63:0] sext_pc(input logic [63:0] pc);
    if (pc >= (64'd1 << (VA - 1))) return pc - (64'd1 << VA);
    return pc;
  endfunction

  function automatic logic [63:0] hdr_of(input ev_t e, input logic [3:0] hart);
    if (e.trap) return (64'd2 << 62) | (64'(hart) << 58);
    return (64'd1 << 62) | (64'(hart) << 58) | (64'(e.rd) << 57) | 64'(e.instr);
  endfunction

  // Packet model: tracks queue contents and predicts every accepted beat
  always @(negedge clk_i) begin
    if (!reset_i) begin
      mcq.delete(); mwb.delete();
      bi = 0; mpkts = 0; movf = 0; prev_stall = 0;
    end else begin
      m_cq_sz0 = mcq.size();
      m_wb_sz0 = mwb.size();
      if (prev_stall) begin
        checks++;
        if (tx_v_o !== 1'b1 || tx_data_o !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: v=%0b data=%h required v=1 data=%h", tx_v_o, tx_data_o, prev_data);
        end
      end
      if (tx_v_o === 1'b0) begin
        checks++;
        if (tx_data_o !== 64'd0) begin
          errors++;
          $display("FAIL idle_data_zero: data=%h required 0", tx_data_o);
        end
      end
      if (tx_v_o === 1'b1 && tx_ready_i) begin
        checks++;
        if (m_cq_sz0 == 0 || (bi == 2 && m_wb_sz0 == 0)) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h required no beat", tx_data_o);
        end else begin
          case (bi)
            0:       m_exp = hdr_of(mcq[0], hartid_i);
            1:       m_exp = mcq[0].trap ? mcq[0].cause : sext_pc(mcq[0].pc);
            default: m_exp = mwb[0];
          endcase
          if (tx_data_o !== m_exp) begin
            errors++;
            $display("FAIL beat%0d: data=%h required %h", bi, tx_data_o, m_exp);
          end
          log_q.push_back(tx_data_o);
          m_fin = (bi == 2) || (bi == 1 && (mcq[0].trap || !mcq[0].rd));
          if (m_fin) begin
            if (bi == 2) void'(mwb.pop_front());
            void'(mcq.pop_front());
            bi = 0;
            mpkts++;
          end else begin
            bi++;
          end
        end
      end
      prev_stall = (tx_v_o === 1'b1) && !tx_ready_i;
      prev_data  = tx_data_o;
      if (commit_v_i || interrupt_v_i) begin
        if (m_cq_sz0 == ELS) movf = 1;
        else begin
          m_ev.trap  = interrupt_v_i;
          m_ev.pc    = 64'(commit_pc_i);
          m_ev.instr = commit_instr_i;
          m_ev.rd    = commit_rd_w_v_i;
          m_ev.cause = cause_i;
          mcq.push_back(m_ev);
        end
      end
      if (wb_v_i) begin
        if (m_wb_sz0 == ELS) movf = 1;
        else mwb.push_back(wb_data_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ev(input bit c, input bit i, input logic [VA-1:0] pc,
                        input logic [31:0] instr, input bit rd, input logic [63:0] cause);
    commit_v_i = c; interrupt_v_i = i; commit_pc_i = pc;
    commit_instr_i = instr; commit_rd_w_v_i = rd; cause_i = cause;
  endtask

  task automatic clr_ev();
    set_ev(0, 0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    clr_ev(); wb_v_i = 0; tx_ready_i = 1; wb_pending = 0;
    reset_i = 0;
    repeat (2) tick();
    reset_i = 1;
    tick();
    log_q.delete();
  endtask

  task automatic drain(input bit rand_ready, input int bound);
    int n = 0;
    while ((mcq.size() != 0 || wb_pending != 0) && n < bound) begin
      tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wb_pending > 0 && $urandom_range(0, 1) == 1) begin
        wb_v_i = 1; wb_data_i = {$urandom, $urandom}; wb_pending--;
      end else wb_v_i = 0;
      tick();
      n++;
    end
    wb_v_i = 0; tx_ready_i = 1;
    repeat (3) tick();
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL drain_timeout: cycles=%0d required < %0d", n, bound);
    end
  endtask

  task automatic test_reset();
    reset_i = 0;
    #1;
    checks++;
    if (tx_v_o !== 1'b0 || tx_data_o !== 64'd0 || overflow_o !== 1'b0 || pkt_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: v=%0b data=%h ovf=%0b pkt=%0d required 0/0/0/0",
               tx_v_o, tx_data_o, overflow_o, pkt_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    hartid_i = 4'd3;
    set_ev(1, 0, 39'h40_0000_0000, 32'h0000_0013, 0, '0);
    tick(); clr_ev();
    drain(0, 100);
    checks++;
    if (log_q.size() != 2 || log_q[0] !== 64'h4C00_0000_0000_0013 || log_q[1] !== 64'hFFFF_FFC0_0000_0000) begin
      errors++;
      $display("FAIL single_beats: n=%0d b0=%h b1=%h required 2 4c00000000000013 ffffffc000000000",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 64'd0, (log_q.size() > 1) ? log_q[1] : 64'd0);
    end
    checks++;
    if (pkt_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL single_pkt_cnt: got %0d required 1", pkt_cnt_o);
    end
  endtask

  task automatic test_rd_write();
    do_reset();
    hartid_i = 4'd1;
    set_ev(1, 0, VA'({$urandom, $urandom}), $urandom, 1, '0);
    tick(); clr_ev();
    repeat (4) tick();
    checks++;
    if (tx_v_o !== 1'b0 || log_q.size() != 2) begin
      errors++;
      $display("FAIL rd_wait_for_wb: v=%0b beats=%0d required v=0 beats=2", tx_v_o, log_q.size());
    end
    wb_v_i = 1; wb_data_i = 64'h0000_0000_DEAD_BEEF;
    tick(); wb_v_i = 0;
    drain(0, 100);
    checks++;
    if (log_q.size() != 3 || log_q[2] !== 64'h0000_0000_DEAD_BEEF || pkt_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL rd_data_beat: n=%0d pkt=%0d required 3 beats ending deadbeef, pkt=1",
               log_q.size(), pkt_cnt_o);
    end
  endtask

  task automatic test_trap();
    do_reset();
    hartid_i = 4'd0;
    set_ev(1, 1, VA'({$urandom, $urandom}), $urandom, 1, 64'h8000_0000_0000_0007);
    tick(); clr_ev();
    drain(0, 100);
    checks++;
    if (log_q.size() != 2 || log_q[0] !== 64'h8000_0000_0000_0000 || log_q[1] !== 64'h8000_0000_0000_0007) begin
      errors++;
      $display("FAIL trap_beats: n=%0d b0=%h b1=%h required 2 8000000000000000 8000000000000007",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 64'd0, (log_q.size() > 1) ? log_q[1] : 64'd0);
    end
    checks++;
    if (pkt_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL trap_pkt_cnt: got %0d required 1", pkt_cnt_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    hartid_i = 4'd5;
    tx_ready_i = 0;
    for (int k = 0; k < 9; k++) begin
      set_ev(1, 0, VA'({$urandom, $urandom}), $urandom, 0, '0);
      tick();
      if (k == 7) begin
        checks++;
        if (overflow_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early: got %0b required 0 after 8 commits", overflow_o);
        end
      end
    end
    clr_ev();
    checks++;
    if (overflow_o !== 1'b1 || log_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_set: ovf=%0b beats=%0d required 1 and 0", overflow_o, log_q.size());
    end
    repeat (5) tick();
    drain(0, 200);
    checks++;
    if (pkt_cnt_o !== 32'd8 || log_q.size() != 16 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: pkt=%0d beats=%0d ovf=%0b required 8 16 1",
               pkt_cnt_o, log_q.size(), overflow_o);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    hartid_i = 4'd2;
    set_ev(1, 0, VA'({$urandom, $urandom}), $urandom, 0, '0);
    tick(); clr_ev();
    repeat (2) tick();
    checks++;
    if (tx_v_o !== 1'b1 || log_q.size() != 1) begin
      errors++;
      $display("FAIL midflight_setup: v=%0b beats=%0d required 1 1", tx_v_o, log_q.size());
    end
    reset_i = 0;
    #1;
    checks++;
    if (tx_v_o !== 1'b0 || pkt_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midflight_async: v=%0b pkt=%0d required 0 0", tx_v_o, pkt_cnt_o);
    end
    repeat (2) tick();
    reset_i = 1;
    repeat (10) tick();
    checks++;
    if (log_q.size() != 1 || pkt_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL midflight_abandon: beats=%0d pkt=%0d required 1 0", log_q.size(), pkt_cnt_o);
    end
    set_ev(0, 1, '0, '0, 0, {$urandom, $urandom});
    tick(); clr_ev();
    drain(0, 100);
    checks++;
    if (pkt_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL midflight_resume: pkt=%0d required 1", pkt_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int total = 0;
    int kind;
    bit rd;
    do_reset();
    hartid_i = 4'($urandom);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < ELS; k++) begin
        kind = $urandom_range(0, 2);
        rd = 1'($urandom);
        set_ev(kind != 1, kind != 0, VA'({$urandom, $urandom}), $urandom, rd, {$urandom, $urandom});
        if (kind == 0 && rd) wb_pending++;
        tx_ready_i = 1'($urandom);
        if (wb_pending > 0 && $urandom_range(0, 1) == 1) begin
          wb_v_i = 1; wb_data_i = {$urandom, $urandom}; wb_pending--;
        end else wb_v_i = 0;
        tick();
        total++;
      end
      clr_ev(); wb_v_i = 0;
      drain(1, 2000);
    end
    checks++;
    if (pkt_cnt_o !== 32'(total) || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: pkt=%0d ovf=%0b required %0d 0", pkt_cnt_o, overflow_o, total);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rd_write();
    test_trap();
    test_overflow();
    test_reset_midflight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
